// File: rtl/sha256_job_scheduler_if.sv
// Bundles the host batch command and the per-core launch/done signals of the
// SHA-256 job scheduler; slave is the scheduler, master is its environment.
interface sha256_job_scheduler_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic                 start;
  logic [31:0]          nonce_base;
  logic [15:0]          num_nonces;
  logic [15:0]          output_addr;
  logic                 done;
  logic [NUM_CORES-1:0] core_start;
  logic [31:0]          core_nonce;
  logic [15:0]          core_output_addr;
  logic [NUM_CORES-1:0] core_done;
  logic [15:0]          jobs_completed;

  modport slave (
    input  start, nonce_base, num_nonces, output_addr, core_done,
    output done, core_start, core_nonce, core_output_addr, jobs_completed
  );

  modport master (
    output start, nonce_base, num_nonces, output_addr, core_done,
    input  done, core_start, core_nonce, core_output_addr, jobs_completed
  );
endinterface

// File: rtl/sha256_job_scheduler.sv
// Round-robin dispatcher of a nonce batch onto NUM_CORES SHA-256 cores,
// tracking each core FREE -> LAUNCHED -> RUNNING -> FREE via its done level.
module sha256_job_scheduler #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned OUT_STRIDE = 8
) (
  input logic                   clk,
  input logic                   reset,
  sha256_job_scheduler_if.slave bus
);

  localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_e;
  typedef enum logic [1:0] {T_FREE, T_LAUNCHED, T_RUNNING} trk_e;

  state_e               state_q, state_d;
  trk_e                 trk_q [NUM_CORES];
  trk_e                 trk_d [NUM_CORES];
  logic [31:0]          nonce_base_q, nonce_base_d;
  logic [15:0]          addr_base_q, addr_base_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [15:0]          job_idx_q, job_idx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [15:0]          jobs_q, jobs_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [31:0]          core_nonce_q, core_nonce_d;
  logic [15:0]          core_addr_q, core_addr_d;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic                 all_free;
  logic [4:0]           fin_cnt;
  logic [16:0]          jobs_sum;
  logic [15:0]          addr_offs;

  assign addr_offs = 16'(OUT_STRIDE) * job_idx_q;

  // First FREE tracker at or after the pointer, wrapping; registered state only,
  // so a core freed on this edge is not picked until the next one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    all_free   = 1'b1;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      logic [PW-1:0] cand;
      cand = PW'((32'(ptr_q) + i) % NUM_CORES);
      if (!pick_found && trk_q[cand] == T_FREE) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      if (trk_q[i] != T_FREE) all_free = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    nonce_base_d = nonce_base_q;
    addr_base_d  = addr_base_q;
    remaining_d  = remaining_q;
    job_idx_d    = job_idx_q;
    ptr_d        = ptr_q;
    jobs_d       = jobs_q;
    core_start_d = '0;
    core_nonce_d = core_nonce_q;
    core_addr_d  = core_addr_q;
    fin_cnt      = '0;
    jobs_sum     = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) trk_d[k] = trk_q[k];

    if (state_q != S_IDLE) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        case (trk_q[k])
          T_LAUNCHED: if (!bus.core_done[k]) trk_d[k] = T_RUNNING;
          T_RUNNING: begin
            if (bus.core_done[k]) begin
              trk_d[k] = T_FREE;
              fin_cnt  = fin_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
      jobs_sum = {1'b0, jobs_q} + 17'(fin_cnt);
      jobs_d   = jobs_sum[16] ? '1 : jobs_sum[15:0];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          nonce_base_d = bus.nonce_base;
          addr_base_d  = bus.output_addr;
          remaining_d  = bus.num_nonces;
          job_idx_d    = '0;
          jobs_d       = '0;
          ptr_d        = '0;
          state_d      = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end else if (pick_found) begin
          core_start_d[pick_idx] = 1'b1;
          core_nonce_d           = nonce_base_q + {16'd0, job_idx_q};
          core_addr_d            = addr_base_q + addr_offs;
          trk_d[pick_idx]        = T_LAUNCHED;
          remaining_d            = remaining_q - 16'd1;
          job_idx_d              = job_idx_q + 16'd1;
          ptr_d = (pick_idx == PW'(NUM_CORES - 1)) ? '0 : pick_idx + PW'(1);
        end
      end
      S_DRAIN: begin
        if (all_free) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nonce_base_q <= '0;
      addr_base_q  <= '0;
      remaining_q  <= '0;
      job_idx_q    <= '0;
      ptr_q        <= '0;
      jobs_q       <= '0;
      core_start_q <= '0;
      core_nonce_q <= '0;
      core_addr_q  <= '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) trk_q[k] <= T_FREE;
    end else begin
      state_q      <= state_d;
      nonce_base_q <= nonce_base_d;
      addr_base_q  <= addr_base_d;
      remaining_q  <= remaining_d;
      job_idx_q    <= job_idx_d;
      ptr_q        <= ptr_d;
      jobs_q       <= jobs_d;
      core_start_q <= core_start_d;
      core_nonce_q <= core_nonce_d;
      core_addr_q  <= core_addr_d;
      for (int unsigned k = 0; k < NUM_CORES; k++) trk_q[k] <= trk_d[k];
    end
  end

  assign bus.done             = (state_q == S_IDLE);
  assign bus.core_start       = core_start_q;
  assign bus.core_nonce       = core_nonce_q;
  assign bus.core_output_addr = core_addr_q;
  assign bus.jobs_completed   = jobs_q;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: behavioural cores with per-core run lengths,
// expected launches queued by the stimulus and popped by a launch monitor.
module tb_sha256_job_scheduler;

  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_job_scheduler_if #(.NUM_CORES(NC)) bus();

  sha256_job_scheduler #(.NUM_CORES(NC), .OUT_STRIDE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: done drops on the edge that samples start, rises run_len edges later.
  int unsigned     run_len [NC];
  int unsigned     cnt     [NC];
  logic [NC-1:0]   cdone;
  assign bus.core_done = cdone;

  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (reset) begin
        cdone[k] <= 1'b1;
        cnt[k]   <= 0;
      end else if (bus.core_start[k]) begin
        cdone[k] <= 1'b0;
        cnt[k]   <= run_len[k];
      end else if (cnt[k] != 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) cdone[k] <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [NC-1:0] oh;
    logic [31:0]   nonce;
    logic [15:0]   addr;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int core, input logic [31:0] n, input logic [15:0] a);
    exp_t e;
    e.oh    = NC'(1) << core;
    e.nonce = n;
    e.addr  = a;
    sb.push_back(e);
  endtask

  logic [NC-1:0] prev_cs = '0;
  always @(negedge clk) begin
    if (!reset && bus.core_start != '0) begin
      exp_t e;
      chk("back_to_back", 32'(bus.core_start & prev_cs), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_launch", 32'(bus.core_start), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("launch_core", 32'(bus.core_start), 32'(e.oh));
        chk("launch_nonce", bus.core_nonce, e.nonce);
        chk("launch_addr", 32'(bus.core_output_addr), 32'(e.addr));
      end
    end
    prev_cs = bus.core_start;
  end

  task automatic start_batch(input logic [31:0] b, input logic [15:0] n, input logic [15:0] a);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.nonce_base  = b;
    bus.num_nonces  = n;
    bus.output_addr = a;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic set_run(input int unsigned r0, input int unsigned r1,
                         input int unsigned r2, input int unsigned r3);
    run_len[0] = r0; run_len[1] = r1; run_len[2] = r2; run_len[3] = r3;
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.nonce_base = '0;
    bus.num_nonces = '0;
    bus.output_addr = '0;
    set_run(5, 5, 5, 5);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_done", 32'(bus.done), 32'd1);
    chk("rst_core_start", 32'(bus.core_start), 32'd0);
    chk("rst_core_nonce", bus.core_nonce, 32'd0);
    chk("rst_core_addr", 32'(bus.core_output_addr), 32'd0);
    chk("rst_jobs", 32'(bus.jobs_completed), 32'd0);

    // Single job
    push(0, 32'h10, 16'h0100);
    start_batch(32'h10, 16'd1, 16'h0100);
    wait_done(cyc);
    chk("single_jobs", 32'(bus.jobs_completed), 32'd1);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    // Six jobs over four cores; a stray start mid-batch must be ignored
    for (int i = 0; i < 4; i++) push(i, 32'(i), 16'(8 * i));
    push(0, 32'd4, 16'd32);
    push(1, 32'd5, 16'd40);
    start_batch(32'd0, 16'd6, 16'h0000);
    @(negedge clk);
    bus.start = 1'b1;
    bus.nonce_base = 32'hDEAD_BEEF;
    bus.num_nonces = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("six_jobs", 32'(bus.jobs_completed), 32'd6);
    chk("six_sb_empty", 32'(sb.size()), 32'd0);

    // Cores 0 and 2 finish on the same edge
    set_run(7, 20, 5, 20);
    push(0, 32'h100, 16'h0200);
    push(1, 32'h101, 16'h0208);
    push(2, 32'h102, 16'h0210);
    push(3, 32'h103, 16'h0218);
    push(0, 32'h104, 16'h0220);
    start_batch(32'h100, 16'd5, 16'h0200);
    cyc = 0;
    while (bus.jobs_completed == 16'd0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("pair_jobs_step", 32'(bus.jobs_completed), 32'd2);
    chk("pair_no_launch_on_free", 32'(bus.core_start), 32'd0);
    wait_done(cyc);
    chk("pair_jobs_total", 32'(bus.jobs_completed), 32'd5);
    chk("pair_sb_empty", 32'(sb.size()), 32'd0);

    // Empty batch
    set_run(5, 5, 5, 5);
    start_batch(32'h55, 16'd0, 16'h0300);
    wait_done(cyc);
    chk("zero_done_low_cycles", 32'(cyc), 32'd2);
    chk("zero_jobs", 32'(bus.jobs_completed), 32'd0);

    // Nonce and address wrap
    push(0, 32'hFFFF_FFFE, 16'hFFF0);
    push(1, 32'hFFFF_FFFF, 16'hFFF8);
    push(2, 32'h0000_0000, 16'h0000);
    start_batch(32'hFFFF_FFFE, 16'd3, 16'hFFF0);
    wait_done(cyc);
    chk("wrap_jobs", 32'(bus.jobs_completed), 32'd3);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while three cores are running
    set_run(30, 30, 30, 30);
    push(0, 32'h50, 16'h0040);
    push(1, 32'h51, 16'h0048);
    push(2, 32'h52, 16'h0050);
    start_batch(32'h50, 16'd3, 16'h0040);
    repeat (8) @(negedge clk);
    chk("mid_sb_empty", 32'(sb.size()), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_done", 32'(bus.done), 32'd1);
    chk("mid_rst_core_start", 32'(bus.core_start), 32'd0);
    chk("mid_rst_jobs", 32'(bus.jobs_completed), 32'd0);
    reset = 1'b0;
    set_run(5, 5, 5, 5);
    push(0, 32'h77, 16'h0010);
    start_batch(32'h77, 16'd1, 16'h0010);
    wait_done(cyc);
    chk("post_rst_jobs", 32'(bus.jobs_completed), 32'd1);
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_job_scheduler.md
Name: sha256_job_scheduler

Overview:
- Round-robin job scheduler that shares NUM_CORES simplified SHA-256 core instances across a batch of nonce jobs.
- Accepts one batch command (base nonce, job count, output base address), launches one core per job, and tracks each core's done level to know when it is free again.
- Reports completion once every job has been dispatched and every core has returned to idle.
- Sits between the top-level bitcoin-hash controller and the array of SHA-256 cores; each core wrapper latches core_nonce and core_output_addr when its core_start is high.

Parameters:
NUM_CORES, 4, number of SHA-256 core instances scheduled (1..16)
OUT_STRIDE, 8, words of output memory reserved per job (one 256-bit hash)

Ports:
clk  input  1  single clock for the block and all cores
reset  input  1  synchronous, active-high reset
start  input  1  batch request; sampled only in IDLE
nonce_base  input  32  nonce assigned to job 0
num_nonces  input  16  jobs in the batch; 0 is legal
output_addr  input  16  word address of job 0's hash output
done  output  1  high while in IDLE
core_start  output  NUM_CORES  one-hot, single-cycle launch pulse
core_nonce  output  32  nonce for the core being launched, valid while core_start is non-zero
core_output_addr  output  16  output address for the launched core, output_addr + OUT_STRIDE*job_idx
core_done  input  NUM_CORES  per-core done level; high when that core is idle
jobs_completed  output  16  jobs finished in the current batch

Behaviour:
- Reset: state IDLE, done=1, core_start=0, core_nonce=0, core_output_addr=0, jobs_completed=0, all per-core trackers FREE, round-robin pointer=0.
- Reset asserted mid-batch: the same values are restored on the next edge. Outstanding jobs are abandoned. Cores are not signalled and are reset by their own reset.
- Top-level states: IDLE, DISPATCH, DRAIN.
- IDLE:
  - start=1: latch nonce_base, num_nonces (as remaining), output_addr; set job_idx=0, jobs_completed=0, pointer=0; go to DISPATCH. done falls the following cycle.
  - start=1 in any other state is ignored.
- DISPATCH, per edge:
  - If remaining>0 and at least one tracker is FREE (registered value), pick the first FREE core scanning from the pointer upward with wrap-around.
  - For that core: register core_start[k]=1, core_nonce=nonce_base+job_idx, core_output_addr=output_addr+OUT_STRIDE*job_idx (16-bit wrap). Set tracker k=LAUNCHED, remaining-1, job_idx+1, pointer=(k+1) mod NUM_CORES.
  - Otherwise register core_start=0.
  - At most one launch per cycle. core_start is never high two consecutive cycles for the same core.
  - When remaining==0, go to DRAIN (a num_nonces=0 batch passes straight through).
- Per-core tracker, active in every non-IDLE state:
  - FREE -> LAUNCHED on dispatch.
  - LAUNCHED -> RUNNING when core_done[k]==0. Waits indefinitely; core_done is still high during the pulse cycle, and the core drops done one cycle after sampling start.
  - RUNNING -> FREE when core_done[k]==1, and jobs_completed increments.
  - Several cores finishing on the same edge: jobs_completed increases by the popcount of those cores. It saturates at 16'hFFFF.
  - A core freed on edge E is eligible for dispatch only from the cycle after E.
- DRAIN: core_start=0. When every tracker is FREE, go to IDLE and done rises. Minimum batch latency, start to done, is 3 cycles plus core run time.
- Nonce arithmetic is 32-bit modulo: base 32'hFFFFFFFF, job 1 gets nonce 0.
- core_nonce and core_output_addr hold their last value when no launch occurs.

Test Plan:
- NUM_CORES=1, num_nonces=1, nonce_base=32'h10, output_addr=16'h0100; core model drops done 1 cycle after start and raises it 5 cycles later -> one core_start[0] pulse with core_nonce=32'h10 and addr 16'h0100; done returns high; jobs_completed=1.
- NUM_CORES=4, num_nonces=6, base 0, equal run time -> launches in core order 0,1,2,3 on consecutive cycles with nonces 0..3; nonces 4,5 go to cores 0,1 after they finish; addresses 0,8,...,40; jobs_completed=6.
- Cores 0 and 2 finish on the same edge -> jobs_completed rises by 2 in one cycle; the next launch goes to whichever of 0 and 2 comes first from the pointer; neither is launched on the freeing edge.
- num_nonces=0 -> no core_start pulse; done is low for exactly 2 cycles, then high; jobs_completed=0.
- nonce_base=32'hFFFFFFFE, num_nonces=3 -> nonces FFFFFFFE, FFFFFFFF, 00000000.
- reset pulsed while 3 cores are RUNNING -> next cycle: done=1, core_start=0, jobs_completed=0; a new start then launches core 0 first.
